// File: rtl/adc_axis_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_axis_pkg
// Brief    : Shared ADC stream widths, decimation range and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package adc_axis_pkg;

  localparam int c_ADC_WIDTH          = 12;
  localparam int c_AXIS_TDATA_WIDTH   = 32;
  localparam int c_LOG2_DECIM_MIN     = 0;
  localparam int c_LOG2_DECIM_MAX     = 8;
  localparam int c_LOG2_DECIM_DEFAULT = 4;

  // A window of 2**log2_decim full-scale samples fits exactly in this width.
  function automatic int acc_width(input int adc_width, input int log2_decim);
    return adc_width + log2_decim;
  endfunction

endpackage : adc_axis_pkg
`default_nettype wire

// File: rtl/adc_axis_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_axis_if
// Brief    : AXI-Stream tvalid/tready/tdata bundle with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface adc_axis_if
  import adc_axis_pkg::*;
#(
  parameter int TDATA_WIDTH = c_AXIS_TDATA_WIDTH
) ();

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface : adc_axis_if
`default_nettype wire

// File: rtl/adc_decim_channel.sv
`default_nettype none
// ============================================================================
// Module   : adc_decim_channel
// Brief    : One boxcar-decimation lane: accumulator, window counter,
//            AXI-Stream output register and sticky overrun flag.
//            ADC_DECIM_ROUND_EN selects round-half-up with saturation.
// Revision : 1.0 - initial release
// ============================================================================
module adc_decim_channel
  import adc_axis_pkg::*;
#(
  parameter int ADC_WIDTH        = c_ADC_WIDTH,
  parameter int AXIS_TDATA_WIDTH = c_AXIS_TDATA_WIDTH,
  parameter int LOG2_DECIM       = c_LOG2_DECIM_DEFAULT
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       en,
  input  logic       clr_overrun,
  adc_axis_if.slave  s_axis,
  adc_axis_if.master m_axis,
  output logic       overrun
);

  localparam int c_ACC_W = acc_width(ADC_WIDTH, LOG2_DECIM);

  logic                 w_take;
  logic                 w_last;
  logic                 w_load_ok;
  logic [ADC_WIDTH-1:0] w_sample;
  logic [ADC_WIDTH-1:0] w_result;

  logic                 r_tvalid;
  logic [ADC_WIDTH-1:0] r_tdata;
  logic                 r_overrun;

  // The ADC source is free-running and cannot be back-pressured.
  assign s_axis.tready = 1'b1;

  assign w_sample  = ADC_WIDTH'(s_axis.tdata);
  assign w_take    = en & s_axis.tvalid;
  assign w_load_ok = ~r_tvalid | m_axis.tready;

  generate
    if (LOG2_DECIM == 0) begin : g_passthru
      assign w_last   = w_take;
      assign w_result = w_sample;
    end else begin : g_window
      logic [LOG2_DECIM-1:0] r_cnt;
      logic [c_ACC_W-1:0]    r_acc;
      logic [c_ACC_W-1:0]    w_sum;

      assign w_sum  = r_acc + c_ACC_W'(w_sample);
      assign w_last = w_take & (r_cnt == '1);

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_cnt <= '0;
          r_acc <= '0;
        end else if (!en) begin
          r_cnt <= '0;
          r_acc <= '0;
        end else if (w_take) begin
          if (w_last) begin
            r_cnt <= '0;
            r_acc <= '0;
          end else begin
            r_cnt <= r_cnt + LOG2_DECIM'(1);
            r_acc <= w_sum;
          end
        end
      end

`ifdef ADC_DECIM_ROUND_EN
      localparam logic [c_ACC_W:0] c_HALF = {{c_ACC_W{1'b0}}, 1'b1} << (LOG2_DECIM - 1);

      logic [c_ACC_W:0]   w_rounded;
      logic [ADC_WIDTH:0] w_quot;

      // One guard bit above the sample width catches any carry from rounding.
      assign w_rounded = {1'b0, w_sum} + c_HALF;
      assign w_quot    = (ADC_WIDTH + 1)'(w_rounded >> LOG2_DECIM);
      assign w_result  = w_quot[ADC_WIDTH] ? {ADC_WIDTH{1'b1}} : w_quot[ADC_WIDTH-1:0];
`else
      assign w_result = ADC_WIDTH'(w_sum >> LOG2_DECIM);
`endif
    end
  endgenerate

  // A result loads only when the slot is empty or is being drained this cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_last && w_load_ok) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_result;
      end else if (r_tvalid && m_axis.tready) begin
        r_tvalid <= 1'b0;
      end

      if (w_last && !w_load_ok) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tdata  = AXIS_TDATA_WIDTH'(r_tdata);
  assign overrun       = r_overrun;

endmodule : adc_decim_channel
`default_nettype wire

// File: rtl/adc_axis_decimator.sv
`default_nettype none
// ============================================================================
// Module   : adc_axis_decimator
// Brief    : Two independent ADC boxcar decimators feeding AXI-Stream masters.
//            ADC_DECIM_ROUND_EN selects round-half-up with saturation.
// Revision : 1.0 - initial release
// ============================================================================
module adc_axis_decimator
  import adc_axis_pkg::*;
#(
  parameter int ADC_WIDTH        = c_ADC_WIDTH,
  parameter int AXIS_TDATA_WIDTH = c_AXIS_TDATA_WIDTH,
  parameter int LOG2_DECIM       = c_LOG2_DECIM_DEFAULT
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       en,
  input  logic       clr_overrun,
  adc_axis_if.slave  s_axis_a,
  adc_axis_if.slave  s_axis_b,
  adc_axis_if.master m_axis_a,
  adc_axis_if.master m_axis_b,
  output logic [1:0] overrun
);

  logic w_overrun_a;
  logic w_overrun_b;

  adc_decim_channel #(
    .ADC_WIDTH        (ADC_WIDTH),
    .AXIS_TDATA_WIDTH (AXIS_TDATA_WIDTH),
    .LOG2_DECIM       (LOG2_DECIM)
  ) u_chan_a (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .en          (en),
    .clr_overrun (clr_overrun),
    .s_axis      (s_axis_a),
    .m_axis      (m_axis_a),
    .overrun     (w_overrun_a)
  );

  adc_decim_channel #(
    .ADC_WIDTH        (ADC_WIDTH),
    .AXIS_TDATA_WIDTH (AXIS_TDATA_WIDTH),
    .LOG2_DECIM       (LOG2_DECIM)
  ) u_chan_b (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .en          (en),
    .clr_overrun (clr_overrun),
    .s_axis      (s_axis_b),
    .m_axis      (m_axis_b),
    .overrun     (w_overrun_b)
  );

  assign overrun = {w_overrun_b, w_overrun_a};

endmodule : adc_axis_decimator
`default_nettype wire

// File: tb/tb_adc_axis_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_axis_decimator
// Brief    : Directed bench for a 4-sample window build plus a pass-through
//            (window of 1) build sharing channel A/B stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_axis_decimator;

`ifdef ADC_DECIM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct packed {
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [11:0]      exp_a;
    logic [11:0]      exp_b;
  } vec_t;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       en;
  logic       clr_overrun;
  logic [1:0] ov;
  logic [1:0] ov0;

  int n_vec = 0;
  int n_err = 0;

  vec_t vecs [5];

  adc_axis_if #(.TDATA_WIDTH(32)) s_a ();
  adc_axis_if #(.TDATA_WIDTH(32)) s_b ();
  adc_axis_if #(.TDATA_WIDTH(32)) m_a ();
  adc_axis_if #(.TDATA_WIDTH(32)) m_b ();
  adc_axis_if #(.TDATA_WIDTH(32)) s0_a ();
  adc_axis_if #(.TDATA_WIDTH(32)) s0_b ();
  adc_axis_if #(.TDATA_WIDTH(32)) m0_a ();
  adc_axis_if #(.TDATA_WIDTH(32)) m0_b ();

  always #5 aclk = ~aclk;

  adc_axis_decimator #(
    .ADC_WIDTH        (12),
    .AXIS_TDATA_WIDTH (32),
    .LOG2_DECIM       (2)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .en          (en),
    .clr_overrun (clr_overrun),
    .s_axis_a    (s_a),
    .s_axis_b    (s_b),
    .m_axis_a    (m_a),
    .m_axis_b    (m_b),
    .overrun     (ov)
  );

  adc_axis_decimator #(
    .ADC_WIDTH        (12),
    .AXIS_TDATA_WIDTH (32),
    .LOG2_DECIM       (0)
  ) dut0 (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .en          (en),
    .clr_overrun (clr_overrun),
    .s_axis_a    (s0_a),
    .s_axis_b    (s0_b),
    .m_axis_a    (m0_a),
    .m_axis_b    (m0_b),
    .overrun     (ov0)
  );

  assign s0_a.tvalid = s_a.tvalid;
  assign s0_a.tdata  = s_a.tdata;
  assign s0_b.tvalid = s_b.tvalid;
  assign s0_b.tdata  = s_b.tdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step_in(input logic va, input logic [31:0] da,
                         input logic vb, input logic [31:0] db);
    s_a.tvalid = va;
    s_a.tdata  = da;
    s_b.tvalid = vb;
    s_b.tdata  = db;
    @(posedge aclk);
    #1;
    s_a.tvalid = 1'b0;
    s_b.tvalid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [31:0] a0, a1, a2, a3,
                              input logic [31:0] b0, b1, b2, b3,
                              input logic [11:0] ea, eb);
    vec_t v;
    v.a     = {a3, a2, a1, a0};
    v.b     = {b3, b2, b1, b0};
    v.exp_a = ea;
    v.exp_b = eb;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(32'd100, 32'd101, 32'd102, 32'd103, 32'd0, 32'd0, 32'd0, 32'd0,
                 RND ? 12'd102 : 12'd101, 12'd0);
    vecs[1] = mk(32'hFFFF_F123, 32'hFFFF_F123, 32'hFFFF_F123, 32'hFFFF_F123,
                 32'hFFF, 32'hFFF, 32'hFFF, 32'hFFF, 12'h123, 12'hFFF);
    vecs[2] = mk(32'd1, 32'd2, 32'd3, 32'd4, 32'hFFF, 32'hFFF, 32'hFFF, 32'hFFE,
                 RND ? 12'd3 : 12'd2, RND ? 12'hFFF : 12'hFFE);
    vecs[3] = mk(32'd7, 32'd0, 32'd0, 32'd0, 32'd2, 32'd2, 32'd2, 32'd3,
                 RND ? 12'd2 : 12'd1, 12'd2);
    vecs[4] = mk(32'h800, 32'h800, 32'd0, 32'd0,
                 32'h1234_5005, 32'h1234_5005, 32'h1234_5005, 32'h1234_5005, 12'h400, 12'd5);

    aresetn      = 1'b0;
    en           = 1'b1;
    clr_overrun  = 1'b0;
    s_a.tvalid   = 1'b0;
    s_a.tdata    = '0;
    s_b.tvalid   = 1'b0;
    s_b.tdata    = '0;
    m_a.tready   = 1'b1;
    m_b.tready   = 1'b1;
    m0_a.tready  = 1'b1;
    m0_b.tready  = 1'b1;

    repeat (2) @(posedge aclk);
    #1;
    chk("rst_a_tvalid", 32'(m_a.tvalid), 32'd0);
    chk("rst_b_tvalid", 32'(m_b.tvalid), 32'd0);
    chk("rst_a_tdata", m_a.tdata, 32'd0);
    chk("rst_b_tdata", m_b.tdata, 32'd0);
    chk("rst_overrun", 32'(ov), 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Table: full windows on both channels, sink always ready.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) begin
        step_in(1'b1, vecs[v].a[i], 1'b1, vecs[v].b[i]);
        chk("l0_a_tvalid", 32'(m0_a.tvalid), 32'd1);
        chk("l0_a_tdata", m0_a.tdata, {20'd0, vecs[v].a[i][11:0]});
        chk("l0_b_tdata", m0_b.tdata, {20'd0, vecs[v].b[i][11:0]});
        if (i < 3) begin
          chk("mid_a_tvalid", 32'(m_a.tvalid), 32'd0);
          chk("mid_b_tvalid", 32'(m_b.tvalid), 32'd0);
        end else begin
          chk("win_a_tvalid", 32'(m_a.tvalid), 32'd1);
          chk("win_b_tvalid", 32'(m_b.tvalid), 32'd1);
          chk("win_a_tdata", m_a.tdata, {20'd0, vecs[v].exp_a});
          chk("win_b_tdata", m_b.tdata, {20'd0, vecs[v].exp_b});
        end
      end
    end
    step_in(1'b0, 32'd0, 1'b0, 32'd0);
    chk("drain_a_tvalid", 32'(m_a.tvalid), 32'd0);
    chk("tbl_overrun", 32'(ov), 32'd0);

    // Stalled sink across two windows: first result held, second dropped.
    m_a.tready = 1'b0;
    for (int i = 0; i < 4; i++) step_in(1'b1, 32'd10, 1'b0, 32'd0);
    chk("stall1_tvalid", 32'(m_a.tvalid), 32'd1);
    chk("stall1_tdata", m_a.tdata, 32'd10);
    chk("stall1_overrun", 32'(ov), 32'd0);
    for (int i = 0; i < 4; i++) step_in(1'b1, 32'd20, 1'b0, 32'd0);
    chk("stall2_tvalid", 32'(m_a.tvalid), 32'd1);
    chk("stall2_tdata", m_a.tdata, 32'd10);
    chk("stall2_overrun", 32'(ov), 32'b01);
    clr_overrun = 1'b1;
    step_in(1'b0, 32'd0, 1'b0, 32'd0);
    clr_overrun = 1'b0;
    chk("clr_overrun", 32'(ov), 32'd0);
    // Set wins over a simultaneous clear.
    for (int i = 0; i < 3; i++) step_in(1'b1, 32'd30, 1'b0, 32'd0);
    clr_overrun = 1'b1;
    step_in(1'b1, 32'd30, 1'b0, 32'd0);
    clr_overrun = 1'b0;
    chk("set_vs_clr_overrun", 32'(ov), 32'b01);
    chk("set_vs_clr_tdata", m_a.tdata, 32'd10);
    clr_overrun = 1'b1;
    step_in(1'b0, 32'd0, 1'b0, 32'd0);
    clr_overrun = 1'b0;
    m_a.tready = 1'b1;
    step_in(1'b0, 32'd0, 1'b0, 32'd0);
    chk("accept_tvalid", 32'(m_a.tvalid), 32'd0);

    // New result lands on the same cycle the held word is accepted.
    m_a.tready = 1'b0;
    for (int i = 0; i < 4; i++) step_in(1'b1, 32'd30, 1'b0, 32'd0);
    chk("b2b_first_tdata", m_a.tdata, 32'd30);
    for (int i = 0; i < 3; i++) step_in(1'b1, 32'd40, 1'b0, 32'd0);
    m_a.tready = 1'b1;
    step_in(1'b1, 32'd40, 1'b0, 32'd0);
    chk("b2b_tvalid", 32'(m_a.tvalid), 32'd1);
    chk("b2b_tdata", m_a.tdata, 32'd40);
    chk("b2b_overrun", 32'(ov), 32'd0);
    step_in(1'b0, 32'd0, 1'b0, 32'd0);
    chk("b2b_drain", 32'(m_a.tvalid), 32'd0);

    // Disable mid-window discards the partial sum and count.
    step_in(1'b1, 32'd50, 1'b1, 32'd60);
    step_in(1'b1, 32'd50, 1'b1, 32'd60);
    en = 1'b0;
    step_in(1'b1, 32'd50, 1'b1, 32'd60);
    en = 1'b1;
    for (int i = 0; i < 3; i++) step_in(1'b1, 32'd8, 1'b1, 32'd8);
    chk("en_mid_a_tvalid", 32'(m_a.tvalid), 32'd0);
    chk("en_mid_b_tvalid", 32'(m_b.tvalid), 32'd0);
    step_in(1'b1, 32'd8, 1'b1, 32'd8);
    chk("en_a_tdata", m_a.tdata, 32'd8);
    chk("en_b_tdata", m_b.tdata, 32'd8);
    chk("en_a_tvalid", 32'(m_a.tvalid), 32'd1);
    step_in(1'b0, 32'd0, 1'b0, 32'd0);

    // Asynchronous reset mid-window with a held word and overrun pending.
    m_a.tready = 1'b0;
    for (int i = 0; i < 8; i++) step_in(1'b1, 32'd7, 1'b0, 32'd0);
    step_in(1'b1, 32'd9, 1'b0, 32'd0);
    step_in(1'b1, 32'd9, 1'b0, 32'd0);
    chk("pre_rst_overrun", 32'(ov), 32'b01);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_a_tvalid", 32'(m_a.tvalid), 32'd0);
    chk("arst_a_tdata", m_a.tdata, 32'd0);
    chk("arst_b_tdata", m_b.tdata, 32'd0);
    chk("arst_overrun", 32'(ov), 32'd0);
    @(posedge aclk);
    #3;
    aresetn    = 1'b1;
    m_a.tready = 1'b1;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 3; i++) step_in(1'b1, 32'd12, 1'b0, 32'd0);
    chk("post_rst_mid_tvalid", 32'(m_a.tvalid), 32'd0);
    step_in(1'b1, 32'd12, 1'b0, 32'd0);
    chk("post_rst_tvalid", 32'(m_a.tvalid), 32'd1);
    chk("post_rst_tdata", m_a.tdata, 32'd12);

    repeat (2) @(posedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_adc_axis_decimator
`default_nettype wire
